// File: rtl/gm_ram_pkg.sv
// Shared definitions for the item RAM arbiter and the clients that use it.
// Holds the read-return owner tags, arbiter state encodings and item RAM widths.
package gm_ram_pkg;

    localparam int unsigned ITEM_ADDR_W = 4;
    localparam int unsigned ITEM_DATA_W = 32;
    localparam int unsigned TAG_W       = 2;

    // Owner of an in-flight read; writes travel as TAG_NONE.
    typedef enum logic [TAG_W-1:0] {
        TAG_NONE = 2'd0,
        TAG_ROP  = 2'd1,
        TAG_DRW  = 2'd2
    } owner_tag_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_tag_pipe.sv
// Read-return tag pipeline: delays the owner tag of each granted access by the
// RAM read latency and turns it into per-client read-valid pulses.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   push_tag       - owner tag of this cycle's granted access (TAG_NONE if none/write)
//   tag_out_c      - tag whose RAM data is on ram_q this cycle
//   rop_rvalid     - registered, rdata belongs to the rope controller
//   drw_rvalid     - registered, rdata belongs to the stone drawer
module ram_tag_pipe
    import gm_ram_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  owner_tag_e push_tag,
    output owner_tag_e tag_out_c,
    output logic       rop_rvalid,
    output logic       drw_rvalid
);

    owner_tag_e tag_q [RD_LATENCY];

    // Shift register; the last stage lines up with valid ram_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= TAG_NONE;
            end
            rop_rvalid <= 1'b0;
            drw_rvalid <= 1'b0;
        end else begin
            tag_q[0] <= push_tag;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rop_rvalid <= (tag_q[RD_LATENCY-1] == TAG_ROP);
            drw_rvalid <= (tag_q[RD_LATENCY-1] == TAG_DRW);
        end
    end

    assign tag_out_c = tag_q[RD_LATENCY-1];

endmodule

// File: rtl/stone_ram_arbiter.sv
// Arbiter owning the single port of the item RAM, shared by the level loader
// (LVL, write-only), rope controller (ROP, read/write with lock) and stone
// drawer (DRW, read-only). LVL has fixed priority, ROP/DRW alternate
// round-robin, and ROP may lock the port for an atomic read-modify-write,
// bounded by LOCK_MAX cycles.
// Ports:
//   clock, reset                         - system clock, synchronous active-high reset
//   lvl_req/addr/wdata, lvl_gnt          - loader write channel
//   rop_req/we/lock/addr/wdata, rop_gnt  - rope channel, rop_rvalid on read return
//   drw_req/addr, drw_gnt                - drawer read channel, drw_rvalid on read return
//   rdata                                - registered read data, qualified by rvalids
//   ram_addr/wdata/we, ram_q             - RAM port
//   locked, lock_timeout                 - lock held / forced release pulse
module stone_ram_arbiter
    import gm_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = ITEM_ADDR_W,
    parameter int unsigned DATA_W     = ITEM_DATA_W,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned LOCK_MAX   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lvl_req,
    input  logic [ADDR_W-1:0] lvl_addr,
    input  logic [DATA_W-1:0] lvl_wdata,
    output logic              lvl_gnt,
    input  logic              rop_req,
    input  logic              rop_we,
    input  logic              rop_lock,
    input  logic [ADDR_W-1:0] rop_addr,
    input  logic [DATA_W-1:0] rop_wdata,
    output logic              rop_gnt,
    output logic              rop_rvalid,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              locked,
    output logic              lock_timeout
);

    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_blocked_q, lock_blocked_d;
    logic              lock_timeout_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic              idle_arb;
    owner_tag_e        push_tag;
    owner_tag_e        tag_out_c;

    // Grant selection and next arbiter state.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;
        lock_blocked_d = lock_blocked_q;
        lock_timeout_d = 1'b0;
        lvl_gnt        = 1'b0;
        rop_gnt        = 1'b0;
        drw_gnt        = 1'b0;
        push_tag       = TAG_NONE;

        // Dropping the lock hands the port back in the same cycle.
        idle_arb = (state_q == S_IDLE) || !rop_lock;

        if (!reset) begin
            if (idle_arb) begin
                if (lvl_req) begin
                    lvl_gnt = 1'b1;
                end else if (rop_req && (!drw_req || !rr_q)) begin
                    rop_gnt = 1'b1;
                end else if (drw_req) begin
                    drw_gnt = 1'b1;
                end
            end else begin
                rop_gnt = rop_req;
            end

            if (state_q == S_LOCKED) begin
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                if (!rop_lock) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = S_IDLE;
                    lock_timeout_d = 1'b1;
                    lock_blocked_d = 1'b1;
                end
            end else if (rop_gnt && rop_lock && !lock_blocked_q) begin
                state_d = S_LOCKED;
                cnt_d   = '0;
            end

            if (!rop_lock) begin
                lock_blocked_d = 1'b0;
            end

            // Point at the client that did not just win; a timeout favours DRW.
            if (rop_gnt) begin
                rr_d = 1'b1;
            end
            if (drw_gnt) begin
                rr_d = 1'b0;
            end
            if (lock_timeout_d) begin
                rr_d = 1'b1;
            end

            if (rop_gnt && !rop_we) begin
                push_tag = TAG_ROP;
            end else if (drw_gnt) begin
                push_tag = TAG_DRW;
            end
        end
    end

    // RAM port follows the granted client; idle keeps the last address.
    always_comb begin
        ram_addr  = last_addr_q;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (lvl_gnt) begin
            ram_addr  = lvl_addr;
            ram_wdata = lvl_wdata;
            ram_we    = 1'b1;
        end else if (rop_gnt) begin
            ram_addr  = rop_addr;
            ram_wdata = rop_wdata;
            ram_we    = rop_we;
        end else if (drw_gnt) begin
            ram_addr  = drw_addr;
        end
    end

    // Arbiter state, lock bookkeeping and read data register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rr_q           <= 1'b0;
            cnt_q          <= '0;
            lock_blocked_q <= 1'b0;
            lock_timeout   <= 1'b0;
            last_addr_q    <= '0;
            rdata          <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            cnt_q          <= cnt_d;
            lock_blocked_q <= lock_blocked_d;
            lock_timeout   <= lock_timeout_d;
            last_addr_q    <= ram_addr;
            if (tag_out_c != TAG_NONE) begin
                rdata <= ram_q;
            end
        end
    end

    assign locked = (state_q == S_LOCKED);

    ram_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .push_tag   (push_tag),
        .tag_out_c  (tag_out_c),
        .rop_rvalid (rop_rvalid),
        .drw_rvalid (drw_rvalid)
    );

endmodule
